// File: rtl/display_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment driver.
// Segment vectors are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [4:0] G_0    = 5'd0;
  localparam logic [4:0] G_1    = 5'd1;
  localparam logic [4:0] G_8    = 5'd8;
  localparam logic [4:0] G_F    = 5'd15;
  localparam logic [4:0] G_G    = 5'd16;
  localparam logic [4:0] G_H    = 5'd17;
  localparam logic [4:0] G_J    = 5'd18;
  localparam logic [4:0] G_L    = 5'd19;
  localparam logic [4:0] G_N    = 5'd20;
  localparam logic [4:0] G_O    = 5'd21;
  localparam logic [4:0] G_P    = 5'd22;
  localparam logic [4:0] G_R    = 5'd23;
  localparam logic [4:0] G_T    = 5'd24;
  localparam logic [4:0] G_U    = 5'd25;
  localparam logic [4:0] G_Y    = 5'd26;
  localparam logic [4:0] G_DASH = 5'd27;
  localparam logic [4:0] G_UNDS = 5'd28;
  localparam logic [4:0] G_DEG  = 5'd29;

  typedef struct packed {
    logic       en;
    logic [4:0] glyph;
  } char_code_t;

  // 0-F hex, then letters/symbols; 30 and 31 are unassigned (blank).
  localparam logic [6:0] GLYPH_TABLE [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E,
    7'h42, 7'h09, 7'h61, 7'h47,
    7'h2B, 7'h23, 7'h0C, 7'h2F,
    7'h07, 7'h41, 7'h11, 7'h3F,
    7'h77, 7'h1C, 7'h7F, 7'h7F
  };

endpackage

// File: rtl/display_driver_glyph.sv
// Glyph index to active-low segment pattern lookup.
// Purely combinational; table lives in display_pkg.
module glyph_decoder
  import display_pkg::*;
(
  input  logic [4:0] i_glyph,
  output logic [6:0] o_seg
);

  // Table lookup; unassigned entries already hold SEG_BLANK.
  always_comb begin
    o_seg = GLYPH_TABLE[i_glyph];
  end

endmodule

// File: rtl/display_driver.sv
// 8-digit multiplexed 7-segment driver with tear-free frame snapshot.
// Optional blink feature: define DISPLAY_DRIVER_BLINK_EN.
module display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_DIV    = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic [7:0] dp,
`ifdef DISPLAY_DRIVER_BLINK_EN
  input  logic [7:0] blink,
`endif
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

  if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV ||
      BLANK_CYCLES < 0 || BLINK_DIV < 1) begin : g_param_err
    $error("display_driver: illegal parameter set");
  end

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  char_code_t    r_snap [8];
  logic [7:0]    r_dp;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp_n;
  logic          r_tick;

  char_code_t    w_in [8];
  char_code_t    w_code;
  logic          w_capture;
  logic          w_slot_end;
  logic          w_wrap;
  logic          w_dp_req;
  logic          w_blink_off;
  logic          w_lit;
  logic [6:0]    w_glyph_seg;

  assign w_slot_end = (r_presc == P_LAST);
  assign w_wrap     = w_slot_end && (r_idx == 3'd7);
  assign w_capture  = (r_presc == '0) && (r_idx == 3'd0);

  // Gather the live character inputs, d1 at slot 0.
  always_comb begin
    w_in[0] = char_code_t'(d1);
    w_in[1] = char_code_t'(d2);
    w_in[2] = char_code_t'(d3);
    w_in[3] = char_code_t'(d4);
    w_in[4] = char_code_t'(d5);
    w_in[5] = char_code_t'(d6);
    w_in[6] = char_code_t'(d7);
    w_in[7] = char_code_t'(d8);
  end

  // Slot prescaler and scan index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
    end else if (w_slot_end) begin
      r_presc <= '0;
      r_idx   <= r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Frame snapshot, taken at the first cycle of slot 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin
        r_snap[k] <= '0;
      end
      r_dp <= 8'h00;
    end else if (w_capture) begin
      for (int k = 0; k < 8; k++) begin
        r_snap[k] <= w_in[k];
      end
      r_dp <= dp;
    end
  end

`ifdef DISPLAY_DRIVER_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] F_LAST = BW'(BLINK_DIV - 1);

  logic [7:0]    r_blink;
  logic [BW-1:0] r_fcnt;
  logic          r_phase;

  // Blink mask snapshot and frame-count driven blink phase.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_blink <= 8'h00;
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      if (w_capture) begin
        r_blink <= blink;
      end
      if (w_wrap) begin
        if (r_fcnt == F_LAST) begin
          r_fcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + BW'(1);
        end
      end
    end
  end

  // Capture cycle is always slot 0, so bypass reads blink[7].
  assign w_blink_off = r_phase &
    (w_capture ? blink[7] : r_blink[3'd7 - r_idx]);
`else
  assign w_blink_off = 1'b0;
`endif

  // Current slot's code; bypass the snapshot on the capture cycle
  // so that a zero-length blank still shows fresh data.
  always_comb begin
    w_code   = r_snap[r_idx];
    w_dp_req = r_dp[3'd7 - r_idx];
    if (w_capture) begin
      w_code   = w_in[0];
      w_dp_req = dp[7];
    end
  end

  assign w_lit = w_code.en && !w_blink_off && (r_presc >= P_BLANK);

  glyph_decoder u_glyph (
    .i_glyph (w_code.glyph),
    .o_seg   (w_glyph_seg)
  );

  // Registered outputs, one cycle behind prescaler/index state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_an   <= 8'hFF;
      r_seg  <= SEG_BLANK;
      r_dp_n <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_lit) begin
        r_an   <= ~(8'h80 >> r_idx);
        r_seg  <= w_glyph_seg;
        r_dp_n <= ~w_dp_req;
      end else begin
        r_an   <= 8'hFF;
        r_seg  <= SEG_BLANK;
        r_dp_n <= 1'b1;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_display_driver.sv
// Scoreboard bench for display_driver (REFRESH_DIV=8, BLANK=2).
// Blink scenario runs when DISPLAY_DRIVER_BLINK_EN is defined.
module tb_display_driver;

  typedef struct {
    int unsigned at;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpn;
    logic        tick;
    bit          chk_seg;
    string       nm;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] d [8];
  logic [7:0] dp;
`ifdef DISPLAY_DRIVER_BLINK_EN
  logic [7:0] blink;
`endif
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp_n;
  logic       frame_tick;

  logic [5:0] ex_code [8];
  logic [7:0] ex_dp;
  logic [7:0] ex_blink;
  logic [6:0] hex_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  exp_t        q [$];
  int unsigned pe = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned b;

  always #5 clock = ~clock;
  always @(posedge clock) pe <= pe + 1;

  display_driver #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2),
    .BLINK_DIV    (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .d1         (d[0]),
    .d2         (d[1]),
    .d3         (d[2]),
    .d4         (d[3]),
    .d5         (d[4]),
    .d6         (d[5]),
    .d7         (d[6]),
    .d8         (d[7]),
    .dp         (dp),
`ifdef DISPLAY_DRIVER_BLINK_EN
    .blink      (blink),
`endif
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  // Monitor: pop expectations due at this cycle and compare.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].at <= pe) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (e.at < pe) begin
        n_fail++;
        $display("FAIL %s key %0d: not sampled, required an=%b",
                 e.nm, e.at, e.an);
      end else if (an !== e.an || frame_tick !== e.tick ||
                   (e.chk_seg && (seg !== e.seg || dp_n !== e.dpn))) begin
        n_fail++;
        $display("FAIL %s key %0d: got an=%b seg=%b dp_n=%b tick=%b, required an=%b seg=%b dp_n=%b tick=%b",
                 e.nm, e.at, an, seg, dp_n, frame_tick,
                 e.an, e.seg, e.dpn, e.tick);
      end
    end
  end

  // Expected scan for cycles n0..n1 after release (minus off).
  task automatic push_range(input int unsigned bb, input int n0,
                            input int n1, input int off,
                            input string nm);
    for (int n = n0; n <= n1; n++) begin
      int r, s, p, f;
      bit ph, en;
      exp_t e;
      r  = n - off;
      s  = ((r - 1) / 8) % 8;
      p  = (r - 1) % 8;
      f  = (r - 1) / 64;
      ph = ((f / 2) % 2) == 1;
      en = ex_code[s][5] && !(ex_blink[7-s] && ph);
      e.at      = bb + n;
      e.nm      = nm;
      e.tick    = (r % 64) == 0;
      e.an      = 8'hFF;
      e.seg     = 7'h7F;
      e.dpn     = 1'b1;
      e.chk_seg = !en;
      if (en && p >= 2) begin
        e.an      = ~(8'h80 >> s);
        e.seg     = hex_seg[ex_code[s][3:0]];
        e.dpn     = ~ex_dp[7-s];
        e.chk_seg = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  task automatic push_rst(input int unsigned at, input string nm);
    exp_t e;
    e.at = at; e.nm = nm; e.an = 8'hFF; e.seg = 7'h7F;
    e.dpn = 1'b1; e.tick = 1'b0; e.chk_seg = 1'b1;
    q.push_back(e);
  endtask

  task automatic hold_reset(input int n);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= n; i++) push_rst(pe + i, "reset_state");
    repeat (n) @(negedge clock);
  endtask

  task automatic do_release(output int unsigned bb);
    reset = 1'b1;
    bb = pe;
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (q.size() > 0 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: %0d expectations never reached, required 0",
               nm, q.size());
      q.delete();
    end
  endtask

  task automatic set_all(input logic [5:0] base, input bit step);
    for (int k = 0; k < 8; k++) d[k] = step ? (base | 6'(k)) : base;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_all(6'd0, 0);
    dp = 8'h00;
    ex_blink = 8'h00;
`ifdef DISPLAY_DRIVER_BLINK_EN
    blink = 8'h00;
`endif
    repeat (2) @(negedge clock);

    // Only d1 lit: '0' on an[7] for cycles 3..8.
    set_all(6'd0, 0);
    d[0] = 6'b100000;
    ex_code = d; ex_dp = dp;
    hold_reset(3);
    do_release(b);
    push_range(b, 1, 64, 0, "d1_only");
    drain("d1_only");

    // All eight digits 0..7, dp on d6, two frames.
    set_all(6'b100000, 1);
    dp = 8'b0000_0100;
    ex_code = d; ex_dp = dp;
    hold_reset(2);
    do_release(b);
    push_range(b, 1, 128, 0, "full_scan");
    drain("full_scan");

    // Mid-frame change of d3 must wait for the next frame.
    set_all(6'd0, 0);
    d[2] = 6'b101000;
    dp = 8'h00;
    ex_code = d; ex_dp = dp;
    hold_reset(2);
    do_release(b);
    push_range(b, 1, 64, 0, "tear_free_f0");
    ex_code[2] = 6'b101111;
    push_range(b, 65, 128, 0, "tear_free_f1");
    repeat (20) @(negedge clock);
    d[2] = 6'b101111;
    drain("tear_free");

    // d5 disabled with dp[3] requested: stays dark.
    set_all(6'b100001, 0);
    d[4] = 6'b011000;
    dp = 8'b0000_1000;
    ex_code = d; ex_dp = dp;
    hold_reset(2);
    do_release(b);
    push_range(b, 1, 64, 0, "disabled_d5");
    drain("disabled_d5");

    // One-cycle reset at cycle 37 aborts the frame.
    set_all(6'b100000, 1);
    dp = 8'h00;
    ex_code = d; ex_dp = dp;
    hold_reset(2);
    do_release(b);
    push_range(b, 1, 36, 0, "pre_abort");
    push_rst(b + 37, "abort_reset");
    push_range(b, 38, 101, 37, "post_abort");
    repeat (36) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    drain("abort");

`ifdef DISPLAY_DRIVER_BLINK_EN
    // d1 blinking: lit frames 0-1, dark 2-3, lit 4-5.
    set_all(6'd0, 0);
    d[0] = 6'b100000;
    dp = 8'h00;
    blink = 8'h80;
    ex_code = d; ex_dp = dp; ex_blink = blink;
    hold_reset(2);
    do_release(b);
    push_range(b, 1, 384, 0, "blink");
    drain("blink");
    ex_blink = 8'h00;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_driver.md
DISPLAY_DRIVER -- requirements
Module: display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range ≥2.
REQ-002 Parameter BLANK_CYCLES, default 16, anti-ghost blank cycles at the start of each slot; legal range < REFRESH_DIV.
REQ-003 Parameter BLINK_DIV, default 250, frames per blink half-period; used only with the blink feature.
REQ-004 The block SHALL have exactly these ports, clock and reset first:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- d1..d8  in  6 each  character codes; bit5 = digit enable, bits[4:0] = glyph index; d1 is leftmost.
- dp  in  8  decimal-point request; dp[7] is d1.
- blink  in  8  per-digit blink mask; present only with the blink feature.
- an  out  8  active-low one-hot anodes; an[7] is d1, an[0] is d8.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- frame_tick  out  1  one-cycle pulse per completed 8-digit frame.

Function
REQ-005 The slot prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the scan index SHALL count 0..7 and wrap, advancing when the prescaler wraps.
REQ-006 Scan index k SHALL select d(k+1) and drive anode an[7-k].
REQ-007 d1..d8 and dp SHALL be captured into a snapshot register when prescaler==0 and index==0, including the first cycle after reset release; between captures the display uses only the snapshot (tear-free).
REQ-008 For prescaler values 0..BLANK_CYCLES-1, an SHALL be 8'hFF; for BLANK_CYCLES..REFRESH_DIV-1, the selected anode SHALL be low.
REQ-009 A digit with enable bit5=0 SHALL keep its anode high for its whole slot, with seg=7'h7F and dp_n=1.
REQ-010 Glyph decode SHALL map index 0–15 to hex 0–F, with '0'=7'b1000000, '1'=7'b1111001, '8'=7'b0000000, 'F'=7'b0001110; indices 16–31 map to the letter table in the package; any unlisted index maps to 7'h7F.
REQ-011 an, seg and dp_n SHALL be registered, with exactly one cycle of latency from prescaler/index state to the outputs.
REQ-012 frame_tick SHALL be high for exactly the one cycle in which the index wraps from 7 to 0.
REQ-013 Input changes in mid-frame SHALL NOT affect outputs until the next capture.

Reset
REQ-014 While reset=0 at a clock edge, the following SHALL be cleared: prescaler=0, index=0, snapshot all-zero (all digits disabled), blink state=0, an=8'hFF, seg=7'h7F, dp_n=1, frame_tick=0.
REQ-015 Reset asserted mid-frame SHALL abort the frame with no frame_tick; scanning SHALL restart at index 0 on the first cycle after release.

Configuration
REQ-016 With macro DISPLAY_DRIVER_BLINK_EN defined, the blink port and a frame counter toggling a blink phase every BLINK_DIV frames SHALL exist; blink is captured with the snapshot, and a digit whose blink bit is 1 SHALL be treated as disabled during the off phase (phase=1).
REQ-017 Without DISPLAY_DRIVER_BLINK_EN, the blink port and blink logic SHALL be absent, and behaviour SHALL be identical to blink mask = 0.

Structure
REQ-018 Package display_pkg SHALL hold the glyph index constants, the 32-entry glyph-to-segment table, the SEG_BLANK constant (7'h7F) and the char_code_t type (6-bit packed struct {en, glyph}).
REQ-019 Sub-module glyph_decoder (combinational, glyph index in, segments out) SHALL be used; all other logic SHALL reside in display_driver.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_DIV=2)
REQ-020 Reset release with d1=6'b100000 and the others 0 -> cycles 3–8 after release: an=8'b01111111, seg=7'b1000000; an=8'hFF elsewhere in the frame.
REQ-021 d1..d8 = 6'b100000..6'b100111 -> each frame shows 8 slots of 8 cycles with anodes stepping an[7]→an[0], and frame_tick pulses every 64 cycles.
REQ-022 d3 changed from 6'b101000 to 6'b101111 at cycle 20 -> slot 2 still shows '8' (7'b0000000) in that frame, and 'F' (7'b0001110) in the next.
REQ-023 d5=6'b011000 (enable=0), dp[3]=1 -> an[3] stays high throughout slot 4, seg=7'h7F, dp_n=1.
REQ-024 reset=0 for one cycle at cycle 37 -> outputs return to reset values, frame_tick does not pulse, and scanning resumes at index 0 (an[7]).
REQ-025 With DISPLAY_DRIVER_BLINK_EN, blink=8'h80, d1 enabled -> d1 is lit in frames 0–1, dark in frames 2–3, and lit again in frames 4–5.
